// File: rtl/ecc_affine_convert_pkg.sv
// Shared definitions for the projective-to-affine converter: FSM state
// encodings and inverter handshake status values.
package ecc_affine_convert_pkg;

  typedef enum logic [3:0] {
    ST_WAIT    = 4'd0,
    ST_REQINV  = 4'd1,
    ST_RELINV  = 4'd2,
    ST_MULX    = 4'd3,
    ST_MULY    = 4'd4,
    ST_DONEOUT = 4'd5
  } conv_state_t;

  // Inverter failure flag values
  localparam logic HS_OK   = 1'b0;
  localparam logic HS_FAIL = 1'b1;

endpackage

// File: rtl/ecc_affine_convert_modmul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier: result = a*b mod p.
// Takes integer_size busy cycles. done is combinational and is high in the last
// busy cycle, with result already showing the final value. This lets the
// caller capture the result and restart the multiplier on the same edge.
module modmul_serial #(
  parameter int integer_size = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [integer_size-1:0] a,
  input  logic [integer_size-1:0] b,
  input  logic [integer_size-1:0] p,
  output logic [integer_size-1:0] result,
  output logic                    busy,
  output logic                    done
);

  localparam int W  = integer_size;
  localparam int CW = $clog2(W + 1);

  logic [W:0]    acc;
  logic [W-1:0]  a_reg, b_sh, p_reg;
  logic [CW-1:0] cnt;
  logic [W:0]    pz, dbl, t1, t2, t3;

  // One interleaved step: double-and-reduce, then conditional add-and-reduce.
  // acc < p always holds, so 2*acc and t1+a both fit in W+1 bits.
  always_comb begin
    pz  = {1'b0, p_reg};
    dbl = acc << 1;
    t1  = (dbl >= pz) ? dbl - pz : dbl;
    t2  = b_sh[W-1] ? t1 + {1'b0, a_reg} : t1;
    t3  = (t2 >= pz) ? t2 - pz : t2;
  end

  assign result = t3[W-1:0];
  assign done   = busy && (cnt == CW'(1));

  // Operand capture on start (start wins over a finishing run), then one bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      a_reg <= '0;
      b_sh  <= '0;
      p_reg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      a_reg <= a;
      b_sh  <= b;
      p_reg <= p;
      cnt   <= CW'(W);
      busy  <= 1'b1;
    end else if (busy) begin
      acc  <= t3;
      b_sh <= b_sh << 1;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ecc_affine_convert.sv
// Projective (X,Y,Z) to affine (x,y) conversion. The block obtains Z^-1 from an
// external inverter through a go/done handshake. It then runs two serial
// modular multiplications on a single shared multiplier.
module ecc_affine_convert
  import ecc_affine_convert_pkg::*;
#(
  parameter int integer_size = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [integer_size-1:0] X,
  input  logic [integer_size-1:0] Y,
  input  logic [integer_size-1:0] Z,
  input  logic [integer_size-1:0] p,
  output logic [integer_size-1:0] x_aff,
  output logic [integer_size-1:0] y_aff,
  output logic                    done,
  output logic                    failure,
  output logic                    inv_go,
  output logic [integer_size-1:0] inv_x,
  output logic [integer_size-1:0] inv_p,
  input  logic [integer_size-1:0] inv_x_inv,
  input  logic                    inv_done,
  input  logic                    inv_failure
);

  localparam int W = integer_size;

  conv_state_t state, state_n;
  logic [W-1:0] x_reg, y_reg, z_reg, p_reg, zinv_reg;
  logic         fail_reg;
  logic         mm_start, mm_busy, mm_done;
  logic [W-1:0] mm_a, mm_result;

  // The multiplier is started from RELINV for x. It is restarted from MULX for y.
  assign mm_a = (state == ST_MULX) ? y_reg : x_reg;

  modmul_serial #(.integer_size(W)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .a      (mm_a),
    .b      (zinv_reg),
    .p      (p_reg),
    .result (mm_result),
    .busy   (mm_busy),
    .done   (mm_done)
  );

  assign done    = (state == ST_DONEOUT);
  assign failure = done && (fail_reg == HS_FAIL);
  assign inv_go  = (state == ST_REQINV);
  assign inv_x   = z_reg;
  assign inv_p   = p_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_n;
  end

  // Next-state logic and multiplier start strobe
  always_comb begin
    state_n  = state;
    mm_start = 1'b0;
    unique case (state)
      ST_WAIT:    if (go) state_n = ST_REQINV;
      ST_REQINV:  if (inv_done) state_n = ST_RELINV;
      ST_RELINV: begin
        if (!inv_done) begin
          if (fail_reg == HS_FAIL) begin
            state_n = ST_DONEOUT;
          end else begin
            state_n  = ST_MULX;
            mm_start = 1'b1;
          end
        end
      end
      ST_MULX: begin
        if (mm_done) begin
          state_n  = ST_MULY;
          mm_start = 1'b1;
        end
      end
      ST_MULY:    if (mm_done) state_n = ST_DONEOUT;
      ST_DONEOUT: if (!go) state_n = ST_WAIT;
      default:    state_n = ST_WAIT;
    endcase
  end

  // Operand capture, inverter result latch and affine result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
      p_reg    <= '0;
      zinv_reg <= '0;
      fail_reg <= HS_OK;
      x_aff    <= '0;
      y_aff    <= '0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          if (go) begin
            x_reg <= X;
            y_reg <= Y;
            z_reg <= Z;
            p_reg <= p;
            x_aff <= '0;
            y_aff <= '0;
          end
        end
        ST_REQINV: begin
          if (inv_done) begin
            zinv_reg <= inv_x_inv;
            fail_reg <= inv_failure;
          end
        end
        ST_MULX: if (mm_done) x_aff <= mm_result;
        ST_MULY: if (mm_done) y_aff <= mm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ecc_affine_convert.md
# ecc_affine_convert

Converts an elliptic-curve point from projective coordinates (X, Y, Z) to affine coordinates (x, y) = (X·Z⁻¹ mod p, Y·Z⁻¹ mod p). It is the initiator side of the go/done/failure inversion handshake: it drives the team's modular inverter (eeageneric) to obtain Z⁻¹. It then performs two bit-serial modular multiplications. It sits between the ECC point-arithmetic datapath and the result/output stage.

## Interface
- integer_size, 64, operand width in bits; must match the inverter instance.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- go  input  1  start request; level, sampled in WAIT.
- X, Y, Z  input  integer_size  projective coordinates; X, Y < p required.
- p  input  integer_size  odd modulus, p ≥ 3.
- x_aff, y_aff  output  integer_size  affine result; valid while done = 1.
- done  output  1  result ready; held until go falls.
- failure  output  1  Z not invertible mod p; meaningful while done = 1.
- inv_go  output  1  inversion request to the inverter.
- inv_x, inv_p  output  integer_size  inverter operands (Z_reg, p_reg).
- inv_x_inv  input  integer_size  inverter result.
- inv_done, inv_failure  input  1  inverter status.

## Operation
- States: WAIT, REQINV, RELINV, MULX, MULY, DONEOUT.
- WAIT
  - Outputs done = 0, failure = 0, inv_go = 0.
  - On go = 1: register X, Y, Z, p; go to REQINV.
  - x_aff and y_aff clear to 0 on go acceptance.
- REQINV
  - inv_go = 1, inv_x = Z_reg, inv_p = p_reg.
  - On inv_done = 1: latch inv_x_inv into zinv_reg and inv_failure into fail_reg; go to RELINV.
- RELINV
  - inv_go = 0.
  - Wait for inv_done = 0. This completes the inverter's handshake.
  - Then go to MULX, or to DONEOUT if fail_reg = 1.
- MULX: compute x_aff = X_reg·zinv_reg mod p, then go to MULY.
- MULY: compute y_aff = Y_reg·zinv_reg mod p, then go to DONEOUT.
- DONEOUT
  - done = 1; failure = fail_reg.
  - On failure, x_aff = y_aff = 0.
  - When go = 0, go to WAIT; done deasserts on the next edge.
- Modular multiply (a·b mod p), MSB-first interleaved, one bit per cycle, integer_size cycles:
  - acc is integer_size+1 bits wide.
  - Each step: acc = 2·acc; if acc ≥ p then acc −= p.
  - If b[i] = 1: acc += a; if acc ≥ p then acc −= p.
  - acc starts at 0.
  - Operands must be < p; the result is < p.
- go held high through DONEOUT does not restart a conversion; go must fall and rise again.
- Reset in any state:
  - Next state is WAIT; all outputs 0, including inv_go.
  - Any inverter transaction in flight is abandoned. The inverter shares reset, so both ends return to idle together.

## Timing
- Reset values: done = 0, failure = 0, inv_go = 0, x_aff = 0, y_aff = 0, state = WAIT.
- Edge-by-edge sequence, with L = inverter latency (edges from inv_go high until inv_done is seen):
  - go sampled at edge 0.
  - inv_go is high from edge 1.
  - zinv is latched at edge 1 + L.
  - RELINV lasts until inv_done falls (≥ 1 cycle).
  - MULX takes integer_size cycles; MULY takes integer_size cycles.
  - done rises on the edge that enters DONEOUT.
- Total latency = 1 + L + t_release + 2·integer_size + 1 cycles.
- inv_x and inv_p are stable for the whole time inv_go = 1.
- x_aff and y_aff change only in MULX/MULY and on go acceptance.

## Structure
- State encodings (4-bit localparams) and handshake status constants go in a shared include, ecc_defs.vh. The point-arithmetic blocks use the same include.
- One sub-module, modmul_serial:
  - Parameter: integer_size.
  - Ports: clk, reset, start, a, b, p, result, busy/done.
  - ecc_affine_convert instantiates it once and reuses it for x and for y.
- The inverter is not instantiated inside this block; it is connected at the next level up.

## Test plan
- integer_size = 8, p = 7, X = 3, Y = 5, Z = 2, bench inverter = eeageneric:
  - Zinv = 4; required x_aff = 5, y_aff = 6, failure = 0.
  - done holds until go falls.
- p = 13, X = 1, Y = 12, Z = 12 -> Zinv = 12; required x_aff = 12, y_aff = 1.
- Z = 0, p = 7 -> inverter reports failure; required failure = 1, x_aff = y_aff = 0, done = 1, with no MULX/MULY cycles.
- Handshake check with a stub inverter that delays inv_done by 20 cycles, then holds inv_done high for 5 cycles after inv_go falls:
  - inv_go must fall exactly one edge after inv_done is seen.
  - MULX must not start until inv_done = 0.
  - inv_x and inv_p must stay stable throughout.
- Assert reset for one cycle midway through MULX (integer_size = 8, p = 251):
  - Next edge: state WAIT, done = 0, inv_go = 0, outputs 0.
  - A fresh go must then produce correct results.
- Back-to-back runs with go held high after done:
  - No second conversion until go falls and rises again.
  - The second run with new operands must give correct results.
